// File: rtl/lsu_ctlr.sv
// Load/store unit: maps core byte accesses onto a 32-bit word RAM. SB/SH use read-modify-write.
// Optional build macro LSU_BOUNDS_CHECK_EN rejects addresses beyond the RAM instead of wrapping them.
module lsu_ctlr #(
  parameter int unsigned RAM_SIZE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned IDX_W = $clog2(RAM_SIZE);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] RMW_WRITE = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]       state;
  logic [IDX_W-1:0] addr_q;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic [15:0]      wdata_q;

  logic             accept;
  logic             req_err;
  logic             f3_illegal;
  logic             misaligned;
  logic             out_of_range;
  logic [IDX_W-1:0] req_idx;
  logic [31:0]      load_data;
  logic [31:0]      rmw_data;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;

  assign req_idx   = req_addr[IDX_W+1:2];
  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  always_comb begin
    f3_illegal = 1'b0;
    if (req_we)
      f3_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
    else
      f3_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  end

  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_BOUNDS_CHECK_EN
  assign out_of_range = |req_addr[31:IDX_W+2];
`else
  // Upper address bits deliberately dropped: the index wraps modulo RAM_SIZE.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:IDX_W+2];
  assign out_of_range   = 1'b0;
`endif

  assign req_err = f3_illegal || misaligned || out_of_range;

  // Lane select and extension of the returning RAM word.
  always_comb begin
    sel_byte = mem_rdata[{off_q, 3'b000} +: 8];
    sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    rmw_data = mem_rdata;
    if (f3_q[1:0] == 2'b01) begin
      if (off_q[1]) rmw_data[31:16] = wdata_q;
      else          rmw_data[15:0]  = wdata_q;
    end else begin
      rmw_data[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // RAM side is combinational so the accept cycle itself carries the read/SW write.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          mem_addr[IDX_W-1:0] = req_idx;
          mem_wdata           = req_wdata;
          mem_we              = accept && !req_err && req_we && (req_funct3 == F3_W);
        end
        LOAD_WAIT: begin
          mem_addr[IDX_W-1:0] = addr_q;
        end
        RMW_WRITE: begin
          mem_addr[IDX_W-1:0] = addr_q;
          mem_wdata           = rmw_data;
          mem_we              = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      addr_q    <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      wdata_q   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_idx;
            off_q   <= req_addr[1:0];
            f3_q    <= req_funct3;
            wdata_q <= req_wdata[15:0];
            if (req_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (!req_we) begin
              state <= LOAD_WAIT;
            end else if (req_funct3 == F3_W) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= '0;
            end else begin
              state <= RMW_WRITE;
            end
          end
        end
        LOAD_WAIT: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= load_data;
          state     <= IDLE;
        end
        RMW_WRITE: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctlr.sv
// Directed bench for lsu_ctlr against a 64-word write-first RAM model with 1-cycle read latency.
module tb_lsu_ctlr;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;

  logic [31:0] ram [0:63];

  lsu_ctlr #(.RAM_SIZE(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr[5:0]] <= mem_wdata;
      mem_rdata          <= mem_wdata;
    end else begin
      mem_rdata <= ram[mem_addr[5:0]];
    end
  end

  always @(posedge clk) if (mem_we === 1'b1) we_cnt++;

  // Called at a negedge; drives one request and waits (bounded) for its response.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    logic got;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_req addr=%h: got %b want 1", addr, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0; lat = 0; rd = '0; er = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (rsp_valid === 1'b1) begin
        got = 1'b1; rd = rsp_rdata; er = rsp_err;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL rsp_timeout addr=%h: no rsp_valid within 8 cycles", addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_00FC; req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_sw();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] a [0:3];
    logic [31:0] d [0:3];
    a[0] = 32'h00; d[0] = 32'h0BAD_F00D;
    a[1] = 32'h0C; d[1] = 32'h8081_F2F3;
    a[2] = 32'h14; d[2] = 32'h1122_3344;
    a[3] = 32'h20; d[3] = 32'h5555_5555;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 3'b010, a[i], d[i], rd, er, lat);
      checks++; if (lat != 1 || er !== 1'b0 || rd !== 32'h0) begin
        errors++; $display("FAIL sw_rsp[%0d]: lat=%0d err=%b rdata=%h want lat=1 err=0 rdata=0", i, lat, er, rd);
      end
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_pulse: got %b want 0", rsp_valid); end
    do_req(1'b1, 3'b010, 32'h18, 32'hDEAD_BEEF, rd, er, lat);
    checks++; if (lat != 1 || er !== 1'b0) begin errors++; $display("FAIL sw_18: lat=%0d err=%b want 1/0", lat, er); end
    do_req(1'b0, 3'b010, 32'h18, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD_BEEF || lat != 2) begin errors++; $display("FAIL lw_18: got %h lat=%0d want deadbeef lat=2", rd, lat); end
  endtask

  task automatic test_loads();
    logic [31:0] rd; logic er; int lat;
    logic [2:0]  f [0:6];
    logic [31:0] a [0:6];
    logic [31:0] e [0:6];
    f[0] = 3'b000; a[0] = 32'h0C; e[0] = 32'hFFFF_FFF3;
    f[1] = 3'b100; a[1] = 32'h0D; e[1] = 32'h0000_00F2;
    f[2] = 3'b101; a[2] = 32'h0E; e[2] = 32'h0000_8081;
    f[3] = 3'b001; a[3] = 32'h0E; e[3] = 32'hFFFF_8081;
    f[4] = 3'b010; a[4] = 32'h0C; e[4] = 32'h8081_F2F3;
    f[5] = 3'b000; a[5] = 32'h0F; e[5] = 32'hFFFF_FF80;
    f[6] = 3'b001; a[6] = 32'h0C; e[6] = 32'hFFFF_F2F3;
    for (int i = 0; i < 7; i++) begin
      do_req(1'b0, f[i], a[i], 32'h0, rd, er, lat);
      checks++; if (rd !== e[i] || er !== 1'b0 || lat != 2) begin
        errors++; $display("FAIL load[%0d] f3=%b addr=%h: got %h err=%b lat=%0d want %h err=0 lat=2",
                            i, f[i], a[i], rd, er, lat, e[i]);
      end
    end
  endtask

  task automatic test_rmw();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 3'b000, 32'h15, 32'h1234_56AA, rd, er, lat);
    checks++; if (lat != 2 || er !== 1'b0) begin errors++; $display("FAIL sb_15: lat=%0d err=%b want 2/0", lat, er); end
    do_req(1'b0, 3'b010, 32'h14, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h1122_AA44) begin errors++; $display("FAIL sb_result: got %h want 1122aa44", rd); end
    do_req(1'b1, 3'b001, 32'h16, 32'hFFFF_BEEF, rd, er, lat);
    checks++; if (lat != 2 || er !== 1'b0) begin errors++; $display("FAIL sh_16: lat=%0d err=%b want 2/0", lat, er); end
    do_req(1'b0, 3'b010, 32'h14, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hBEEF_AA44) begin errors++; $display("FAIL sh_result: got %h want beefaa44", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; int cnt0;
    logic        w [0:4];
    logic [2:0]  f [0:4];
    logic [31:0] a [0:4];
    w[0] = 1'b0; f[0] = 3'b010; a[0] = 32'h02;
    w[1] = 1'b1; f[1] = 3'b001; a[1] = 32'h01;
    w[2] = 1'b0; f[2] = 3'b001; a[2] = 32'h03;
    w[3] = 1'b0; f[3] = 3'b011; a[3] = 32'h00;
    w[4] = 1'b1; f[4] = 3'b100; a[4] = 32'h00;
    cnt0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      do_req(w[i], f[i], a[i], 32'hFFFF_FFFF, rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
        errors++; $display("FAIL err[%0d] we=%b f3=%b addr=%h: err=%b rdata=%h lat=%0d want 1/0/1",
                            i, w[i], f[i], a[i], er, rd, lat);
      end
    end
    checks++; if (we_cnt != cnt0) begin errors++; $display("FAIL err_no_write: mem_we pulses %0d want 0", we_cnt - cnt0); end
    do_req(1'b0, 3'b010, 32'h00, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL err_ram_unchanged: got %h want 0badf00d", rd); end
  endtask

  task automatic test_reset_mid_rmw();
    logic [31:0] rd; logic er; int lat; int cnt0;
    cnt0 = we_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h0000_00AA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_rmw_mem_we: got %b want 0", mem_we); end
    repeat (2) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
        errors++; $display("FAIL rst_rmw_quiet: rsp_valid=%b req_ready=%b want 0/0", rsp_valid, req_ready);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_rmw_resume: req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
    end
    checks++; if (we_cnt != cnt0) begin errors++; $display("FAIL rst_rmw_no_write: mem_we pulses %0d want 0", we_cnt - cnt0); end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h5555_5555) begin errors++; $display("FAIL rst_rmw_word8: got %h want 55555555", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat);
`ifdef LSU_BOUNDS_CHECK_EN
    checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
      errors++; $display("FAIL bounds_100: err=%b rdata=%h lat=%0d want 1/0/1", er, rd, lat);
    end
`else
    checks++; if (er !== 1'b0 || rd !== 32'h0BAD_F00D || lat != 2) begin
      errors++; $display("FAIL wrap_100: err=%b rdata=%h lat=%0d want 0/0badf00d/2", er, rd, lat);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd0, rd1, rd2; logic er; int l0, l1, l2;
    do_req(1'b0, 3'b010, 32'h0C, 32'h0, rd0, er, l0);
    do_req(1'b0, 3'b010, 32'h14, 32'h0, rd1, er, l1);
    do_req(1'b0, 3'b100, 32'h1B, 32'h0, rd2, er, l2);
    checks++; if (rd0 !== 32'h8081_F2F3 || rd1 !== 32'hBEEF_AA44 || rd2 !== 32'h0000_00DE) begin
      errors++; $display("FAIL b2b_data: got %h %h %h want 8081f2f3 beefaa44 000000de", rd0, rd1, rd2);
    end
    checks++; if (l0 + l1 + l2 != 6) begin errors++; $display("FAIL b2b_cycles: got %0d want 6", l0 + l1 + l2); end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    test_reset();
    test_sw();
    test_loads();
    test_rmw();
    test_errors();
    test_reset_mid_rmw();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctlr.md
Name: lsu_ctlr

Overview:
- Load/store unit between the RISC-V core's memory stage and the word-addressed RAM controller (32-bit words, 1-cycle registered read, write-first, no byte enables).
- Converts core byte addresses to word indices.
- Performs LB/LH/LW/LBU/LHU extraction with sign/zero extension.
- Implements SB/SH as read-modify-write; flags misaligned or illegal accesses without touching RAM.

Parameters:
- RAM_SIZE, 64, RAM depth in 32-bit words; power of two.
- IDX_W, $clog2(RAM_SIZE), word-index width (derived, not overridden).

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- rsp_valid  out  1  one-cycle pulse, response ready.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected, misaligned or illegal.
- mem_addr  out  32  word index to RAM; upper bits zero.
- mem_wdata  out  32  word to write.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  32  RAM read data; valid the cycle after the address is presented.

Behaviour:
- States: IDLE, LOAD_WAIT, RMW_WRITE.
- req_ready = (state == IDLE) && rst_n.
- Accept occurs when req_valid && req_ready.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0.
- While rst_n is low, mem_we = 0 and mem_addr = 0.
- Word index = req_addr[IDX_W+1:2], latched at accept and held in the internal registers addr_q, off_q (= addr[1:0]), f3_q, wdata_q.
- mem_addr/mem_we/mem_wdata are combinational from state, and from the request in IDLE.

Error check (at accept):
- H/HU need addr[0]==0; W needs addr[1:0]==0.
- Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
- On error: no RAM access (mem_we=0); next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; state stays IDLE.

Load:
- Cycle T accept: mem_addr = index, mem_we=0; go to LOAD_WAIT.
- T+1: select the byte/half at off_q from mem_rdata; sign-extend (B/H) or zero-extend (BU/HU); register the result; go to IDLE.
- T+2: rsp_valid=1 with data. Latency 2.
- A new request may be accepted in T+2 (back-to-back, one request every 2 cycles).

SW:
- Accept cycle: mem_we=1, mem_wdata=req_wdata.
- Next cycle: rsp_valid=1, rsp_err=0. Latency 1.

SB/SH:
- Accept cycle: mem_we=0, read index; go to RMW_WRITE.
- RMW_WRITE: mem_we=1, mem_addr=addr_q, mem_wdata = mem_rdata with byte lane off_q (or half lane off_q[1]) replaced by wdata_q[7:0]/[15:0].
- Then go to IDLE; rsp_valid next cycle. Latency 2.

rsp_valid is deasserted every cycle it is not set; there is no backpressure on the response.

Reset mid-operation:
- Async return to IDLE; any pending RMW write is abandoned, so the RAM word is unchanged.
- rsp_valid cleared.

Address wrap: without the optional feature, byte addresses ≥ 4*RAM_SIZE alias modulo RAM size.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
- Defined: a request with req_addr[31:IDX_W+2] != 0 is an error, handled identically to misalignment (no RAM access, rsp_err=1 next cycle).
- Undefined: upper address bits are ignored and the index wraps modulo RAM_SIZE.

Test Plan:
- Preload word 3 = 0x8081_F2F3; LB addr 0x0C -> rsp at T+2, rdata 0xFFFF_FFF3; LBU 0x0D -> 0x0000_00F2; LHU 0x0E -> 0x0000_8081; LH 0x0E -> 0xFFFF_8081.
- Word 5 = 0x1122_3344; SB addr 0x15 data 0xAA -> rsp_valid at T+2, rsp_err 0; then LW 0x14 -> 0x1122_AA44.
- SH 0x16 data 0xBEEF on word 5 -> word 0xBEEF_AA44. SW 0x18 data 0xDEAD_BEEF -> rsp at T+1; LW 0x18 -> 0xDEAD_BEEF.
- LW 0x02, SH 0x01, LH 0x03, funct3 011 -> each rsp_err=1, rdata 0, mem_we never asserted, RAM unchanged.
- Assert rst_n low in the RMW_WRITE cycle of SB 0x20 (word 8 = 0x5555_5555) -> no rsp, req_ready returns after reset, word 8 still 0x5555_5555.
- LW 0x100 with RAM_SIZE=64: with LSU_BOUNDS_CHECK_EN -> rsp_err=1; without -> returns word 0.
